// File: rtl/wbs_picorv_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wbs_picorv_bridge
// Brief    : Wishbone B4 pipelined slave to PicoRV32 native memory master.
//            Two-entry request FIFO, one downstream access at a time,
//            out-of-range and timeout error terminations, cycle abort.
// Revision : 1.0 - initial release
// ============================================================================
module wbs_picorv_bridge #(
    parameter logic [31:0] MEM_WORDS      = 32'd16384,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_stall_o,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [29:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i
);

    // Last counter value of a live access; ready on this cycle still wins.
    localparam logic [15:0] C_TMO_LAST = TIMEOUT_CYCLES - 16'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      r_state;

    logic [27:0] r_fifo_adr [2];
    logic [31:0] r_fifo_dat [2];
    logic [3:0]  r_fifo_sel [2];
    logic        r_fifo_we  [2];
    logic        r_fifo_oor [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic [15:0] r_tmo;
    logic        r_cur_we;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_valid;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic        w_accept;
    logic        w_pop;
    logic        w_have_head;
    logic        w_head_oor;
    logic        w_oor_in;
    logic        w_tmo_hit;

    assign wbs_stall_o = (r_count == 2'd2);
    assign wbs_ack_o   = r_ack;
    assign wbs_err_o   = r_err;
    assign wbs_dat_o   = r_rdata;
    assign mem_valid_o = r_valid;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_wstrb_o = r_wstrb;

    assign w_accept    = wbs_cyc_i & wbs_stb_i & ~wbs_stall_o;
    assign w_oor_in    = ({4'b0000, wbs_adr_i} >= MEM_WORDS);
    assign w_have_head = (r_count != 2'd0);
    assign w_head_oor  = r_fifo_oor[r_rd_ptr];
    assign w_tmo_hit   = (r_tmo == C_TMO_LAST);

    // The head leaves the FIFO when rejected as out of range or when its access ends.
    assign w_pop = wbs_cyc_i &
                   (((r_state == IDLE) & w_have_head & w_head_oor) |
                    ((r_state == ISSUE) & (mem_ready_i | w_tmo_hit)));

    // FIFO payload storage; contents are qualified by the count, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo_adr[r_wr_ptr] <= wbs_adr_i;
            r_fifo_dat[r_wr_ptr] <= wbs_dat_i;
            r_fifo_sel[r_wr_ptr] <= wbs_sel_i;
            r_fifo_we[r_wr_ptr]  <= wbs_we_i;
            r_fifo_oor[r_wr_ptr] <= w_oor_in;
        end
    end

    // FIFO pointers and occupancy; dropping cyc discards every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (!wbs_cyc_i) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_accept) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)    r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
        end
    end

    // Access sequencer with registered Wishbone responses and memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tmo    <= 16'd0;
            r_cur_we <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_valid  <= 1'b0;
            r_addr   <= 30'd0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (wbs_cyc_i && w_have_head) begin
                        if (w_head_oor) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state  <= ISSUE;
                            r_valid  <= 1'b1;
                            r_addr   <= {2'b00, r_fifo_adr[r_rd_ptr]};
                            r_wdata  <= r_fifo_dat[r_rd_ptr];
                            r_wstrb  <= r_fifo_we[r_rd_ptr] ? r_fifo_sel[r_rd_ptr] : 4'b0000;
                            r_cur_we <= r_fifo_we[r_rd_ptr];
                            r_tmo    <= 16'd0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready_i) begin
                        // RESP drops the ack itself if the cycle was abandoned meanwhile.
                        r_valid <= 1'b0;
                        if (!r_cur_we && wbs_cyc_i) r_rdata <= mem_rdata_i;
                        r_state <= RESP;
                    end else if (w_tmo_hit) begin
                        r_valid <= 1'b0;
                        r_err   <= wbs_cyc_i;
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                        if (!wbs_cyc_i) r_state <= DRAIN;
                    end
                end
                RESP: begin
                    r_ack   <= wbs_cyc_i;
                    r_state <= IDLE;
                end
                DRAIN: begin
                    // The memory side cannot be cancelled, so wait it out silently.
                    if (mem_ready_i || w_tmo_hit) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wbs_picorv_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbs_picorv_bridge
// Brief    : Self-checking bench for wbs_picorv_bridge (MEM_WORDS=16,
//            TIMEOUT_CYCLES=4): vector table, directed corner sequences and
//            a randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wbs_picorv_bridge;

    localparam int C_WORDS = 16;
    localparam int C_TMO   = 4;

    logic        clk;
    logic        rst_n;
    logic [27:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        wbs_stall_o;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [29:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;

    wbs_picorv_bridge #(
        .MEM_WORDS      (32'd16),
        .TIMEOUT_CYCLES (16'd4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_err_o   (wbs_err_o),
        .wbs_stall_o (wbs_stall_o),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory-side responder ----------------
    // resp_mode 0: random latency, backed by resp_mem; 1: directed latency/data.
    int          resp_mode   = 1;
    int          dir_latency = 0;
    logic [31:0] dir_rdata   = 32'd0;
    logic [31:0] resp_mem [C_WORDS];
    int          lat_q[$];
    int          vcnt;
    int          cur_lat;

    initial begin
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'd0;
        vcnt        = 0;
        cur_lat     = 0;
        forever begin
            @(posedge clk); #1;
            mem_ready_i = 1'b0;
            if (mem_valid_o) begin
                if (vcnt == 0) begin
                    if (resp_mode == 0) begin
                        cur_lat = int'($urandom_range(0, 5));
                        lat_q.push_back(cur_lat);
                    end else begin
                        cur_lat = dir_latency;
                    end
                end
                if (vcnt == cur_lat) begin
                    mem_ready_i = 1'b1;
                    if (resp_mode == 0) begin
                        mem_rdata_i = resp_mem[mem_addr_o[3:0]];
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb_o[b]) resp_mem[mem_addr_o[3:0]][8*b +: 8] = mem_wdata_o[8*b +: 8];
                    end else begin
                        mem_rdata_i = dir_rdata;
                    end
                end
                vcnt++;
            end else begin
                vcnt = 0;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [27:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          lat;
        logic [31:0] rdata;
        logic        exp_ack;
        logic [31:0] exp_dat;
        logic [3:0]  exp_wstrb;
        int          exp_vcyc;
    } vec_t;

    vec_t vecs [8];

    // One isolated transaction; called at #1 after a posedge with the bridge idle.
    task automatic apply_vec(input vec_t v, input int idx);
        int   vcyc;
        int   nresp;
        logic got_ack;
        logic addr_ok;
        logic [3:0] wstrb_seen;
        resp_mode   = 1;
        dir_latency = v.lat;
        dir_rdata   = v.rdata;
        chk($sformatf("vec%0d_stall_idle", idx), 32'(wbs_stall_o), 32'd0);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = v.we;
        wbs_adr_i = v.adr;
        wbs_dat_i = v.dat;
        wbs_sel_i = v.sel;
        @(posedge clk); #1;
        wbs_stb_i  = 1'b0;
        vcyc       = 0;
        nresp      = 0;
        got_ack    = 1'b0;
        addr_ok    = 1'b1;
        wstrb_seen = 4'd0;
        for (int t = 0; t < 30; t++) begin
            if (mem_valid_o) begin
                vcyc++;
                wstrb_seen = mem_wstrb_o;
                if (mem_addr_o != {2'b00, v.adr}) addr_ok = 1'b0;
                if (v.we && mem_wdata_o != v.dat) addr_ok = 1'b0;
            end
            if (wbs_ack_o) begin nresp++; got_ack = 1'b1; end
            if (wbs_err_o) nresp++;
            @(posedge clk); #1;
        end
        chk($sformatf("vec%0d_resp_count", idx), 32'(nresp), 32'd1);
        chk($sformatf("vec%0d_ack_vs_err", idx), 32'(got_ack), 32'(v.exp_ack));
        chk($sformatf("vec%0d_valid_cycles", idx), 32'(vcyc), 32'(v.exp_vcyc));
        chk($sformatf("vec%0d_wstrb", idx), 32'(wstrb_seen), 32'(v.exp_wstrb));
        chk($sformatf("vec%0d_addr_data", idx), 32'(addr_ok), 32'd1);
        chk($sformatf("vec%0d_dat_o", idx), wbs_dat_o, v.exp_dat);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},   32'(wbs_ack_o),   32'd0);
        chk({tag, "_err"},   32'(wbs_err_o),   32'd0);
        chk({tag, "_stall"}, 32'(wbs_stall_o), 32'd0);
        chk({tag, "_dat"},   wbs_dat_o,        32'd0);
        chk({tag, "_valid"}, 32'(mem_valid_o), 32'd0);
        chk({tag, "_addr"},  32'(mem_addr_o),  32'd0);
        chk({tag, "_wdata"}, mem_wdata_o,      32'd0);
        chk({tag, "_wstrb"}, 32'(mem_wstrb_o), 32'd0);
    endtask

    // ---------------- randomized reference model ----------------
    typedef struct {
        logic        we;
        logic [27:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] ref_mem [C_WORDS];
    logic        prev_valid;

    // Expected outcome per request: out of range -> err; otherwise ack if the
    // memory answered within TIMEOUT cycles of valid, else err.
    task automatic sb_cycle();
        req_t r;
        int   lat;
        logic exp_ack;
        if (mem_valid_o && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("rand_issue_without_request", 32'd1, 32'd0);
            end else begin
                r = exp_q[0];
                chk("rand_issue_addr", 32'(mem_addr_o), 32'(r.adr));
                chk("rand_issue_wstrb", 32'(mem_wstrb_o), r.we ? 32'(r.sel) : 32'd0);
                if (r.we) chk("rand_issue_wdata", mem_wdata_o, r.dat);
            end
        end
        prev_valid = mem_valid_o;
        if (wbs_ack_o || wbs_err_o) begin
            chk("rand_ack_err_exclusive", 32'(wbs_ack_o & wbs_err_o), 32'd0);
            if (exp_q.size() == 0) begin
                chk("rand_unexpected_response", 32'd1, 32'd0);
            end else begin
                r = exp_q.pop_front();
                if (int'(r.adr) >= C_WORDS) begin
                    exp_ack = 1'b0;
                end else if (lat_q.size() == 0) begin
                    chk("rand_response_without_access", 32'd1, 32'd0);
                    exp_ack = 1'b0;
                end else begin
                    lat     = lat_q.pop_front();
                    exp_ack = (lat < C_TMO);
                end
                chk("rand_resp_kind", 32'(wbs_ack_o), 32'(exp_ack));
                if (exp_ack && wbs_ack_o) begin
                    if (r.we) begin
                        for (int b = 0; b < 4; b++)
                            if (r.sel[b]) ref_mem[r.adr[3:0]][8*b +: 8] = r.dat[8*b +: 8];
                    end else begin
                        chk("rand_read_data", wbs_dat_o, ref_mem[r.adr[3:0]]);
                    end
                end
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   n_acc;
        int   n_ack;
        int   n_err;
        int   n_rise;
        int   vcyc;
        int   waited;
        logic pv;
        logic will_acc;
        logic first_stall;
        logic got_stall;
        logic [29:0] issued [$];
        logic hold;

        rst_n     = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 28'd0;
        wbs_dat_i = 32'd0;
        wbs_sel_i = 4'd0;
        prev_valid = 1'b0;

        vecs[0] = '{1'b0, 28'h5,       32'h0,        4'hF,    2,   32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 4'b0000, 3};
        vecs[1] = '{1'b1, 28'h3,       32'h12345678, 4'b0011, 0,   32'h0,        1'b1, 32'hDEADBEEF, 4'b0011, 1};
        vecs[2] = '{1'b0, 28'h10,      32'h0,        4'hF,    0,   32'h0,        1'b0, 32'hDEADBEEF, 4'b0000, 0};
        vecs[3] = '{1'b0, 28'hF,       32'h0,        4'hF,    1,   32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 4'b0000, 2};
        vecs[4] = '{1'b0, 28'h7,       32'h0,        4'hF,    255, 32'h11111111, 1'b0, 32'hCAFEF00D, 4'b0000, 4};
        vecs[5] = '{1'b1, 28'hFFFFFFF, 32'h55AA55AA, 4'hF,    0,   32'h0,        1'b0, 32'hCAFEF00D, 4'b0000, 0};
        vecs[6] = '{1'b0, 28'h1,       32'h0,        4'hF,    3,   32'h0BADF00D, 1'b1, 32'h0BADF00D, 4'b0000, 4};
        vecs[7] = '{1'b1, 28'h2,       32'hA5A5A5A5, 4'b1010, 255, 32'h0,        1'b0, 32'h0BADF00D, 4'b1010, 4};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n     = 1'b1;
        wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("post_reset");

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

        // Pipelined writes with a slow memory: two fill the FIFO, third waits.
        resp_mode   = 1;
        dir_latency = 2;
        n_acc = 0; n_ack = 0; n_err = 0; pv = 1'b0;
        got_stall = 1'b0; first_stall = 1'b0;
        issued.delete();
        for (int t = 0; t < 60; t++) begin
            if (n_acc < 3) begin
                wbs_stb_i = 1'b1;
                wbs_we_i  = 1'b1;
                wbs_sel_i = 4'b0011;
                wbs_adr_i = 28'h8 + 28'(n_acc);
                wbs_dat_i = 32'h11110000 + 32'(n_acc);
            end else begin
                wbs_stb_i = 1'b0;
            end
            if (n_acc == 2 && !got_stall) begin
                got_stall   = 1'b1;
                first_stall = wbs_stall_o;
            end
            will_acc = wbs_stb_i && !wbs_stall_o;
            @(posedge clk); #1;
            if (will_acc) n_acc++;
            if (mem_valid_o && !pv) begin
                issued.push_back(mem_addr_o);
                chk("pipe_wstrb", 32'(mem_wstrb_o), 32'h3);
            end
            pv = mem_valid_o;
            if (wbs_ack_o) n_ack++;
            if (wbs_err_o) n_err++;
        end
        chk("pipe_stall_after_two", 32'(first_stall), 32'd1);
        chk("pipe_accepts", 32'(n_acc), 32'd3);
        chk("pipe_acks", 32'(n_ack), 32'd3);
        chk("pipe_errs", 32'(n_err), 32'd0);
        chk("pipe_issue_count", 32'(issued.size()), 32'd3);
        for (int k = 0; k < 3 && k < issued.size(); k++)
            chk($sformatf("pipe_order%0d", k), 32'(issued[k]), 32'h8 + 32'(k));

        // Abort: two reads queued, cyc dropped during the first one's ISSUE.
        dir_latency = 2;
        wbs_we_i  = 1'b0;
        wbs_stb_i = 1'b1;
        wbs_adr_i = 28'h4;
        @(posedge clk); #1;
        wbs_adr_i = 28'h5;
        @(posedge clk); #1;
        wbs_stb_i = 1'b0;
        waited = 0;
        while (!mem_valid_o && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("abort_first_issued", 32'(mem_valid_o), 32'd1);
        chk("abort_first_addr", 32'(mem_addr_o), 32'h4);
        wbs_cyc_i = 1'b0;
        vcyc = 0; n_ack = 0; n_err = 0; n_rise = 0; pv = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (mem_valid_o) vcyc++;
            if (mem_valid_o && !pv) n_rise++;
            pv = mem_valid_o;
            if (wbs_ack_o) n_ack++;
            if (wbs_err_o) n_err++;
            if (t == 10) wbs_cyc_i = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_valid_held", 32'(vcyc), 32'd3);
        chk("abort_no_ack", 32'(n_ack), 32'd0);
        chk("abort_no_err", 32'(n_err), 32'd0);
        chk("abort_second_not_issued", 32'(n_rise), 32'd0);

        // Reset during ISSUE: valid drops at once, nothing answers, bridge usable after.
        dir_latency = 255;
        wbs_stb_i = 1'b1;
        wbs_adr_i = 28'h6;
        @(posedge clk); #1;
        wbs_stb_i = 1'b0;
        waited = 0;
        while (!mem_valid_o && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("rstmid_issued", 32'(mem_valid_o), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid_drop", 32'(mem_valid_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_reset_outputs("rstmid");
        n_ack = 0; n_err = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) n_ack++;
            if (wbs_err_o) n_err++;
        end
        chk("rstmid_no_response", 32'(n_ack + n_err), 32'd0);
        apply_vec('{1'b0, 28'h6, 32'h0, 4'hF, 1, 32'h600D600D, 1'b1, 32'h600D600D, 4'b0000, 2}, 8);

        // Randomized traffic against the reference model.
        resp_mode  = 0;
        prev_valid = 1'b0;
        hold       = 1'b0;
        lat_q.delete();
        exp_q.delete();
        for (int i = 0; i < C_WORDS; i++) begin
            resp_mem[i] = 32'hA5A50000 ^ (32'(i) * 32'h01030507);
            ref_mem[i]  = 32'hA5A50000 ^ (32'(i) * 32'h01030507);
        end
        wbs_cyc_i = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if (!hold) begin
                wbs_stb_i = 1'($urandom_range(0, 1));
                wbs_we_i  = 1'($urandom_range(0, 1));
                wbs_adr_i = 28'($urandom_range(0, 19));
                wbs_dat_i = $urandom;
                wbs_sel_i = 4'($urandom_range(0, 15));
            end
            if (wbs_stb_i && !wbs_stall_o) begin
                exp_q.push_back('{wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i});
                hold = 1'b0;
            end else begin
                hold = wbs_stb_i;
            end
            @(posedge clk); #1;
            sb_cycle();
        end
        wbs_stb_i = 1'b0;
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) begin
            @(posedge clk); #1;
            sb_cycle();
        end
        chk("rand_all_responded", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
